// File: rtl/kgp_pc_pkg.sv
// ============================================================================
// kgp_pc_pkg : shared defaults, FSM encoding and stack-op type for pc_sequencer
// Revision   : 1.0
// ============================================================================
`default_nettype none

package kgp_pc_pkg;

   localparam int unsigned PC_W_DEF      = 32;
   localparam int unsigned RESET_VEC_DEF = 0;
   localparam int unsigned INC_DEF       = 4;
   localparam int unsigned RAS_DEPTH_DEF = 4;

   typedef logic [0:0] pc_state_t;
   localparam pc_state_t ST_RUN  = 1'b0;
   localparam pc_state_t ST_HALT = 1'b1;

   typedef enum logic [1:0] {
      RAS_NOP  = 2'd0,
      RAS_PUSH = 2'd1,
      RAS_POP  = 2'd2
   } ras_op_t;

   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pc_ras.sv
// ============================================================================
// pc_ras : circular return-address stack with sticky overflow/underflow flags
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_ras
   import kgp_pc_pkg::*;
#(
   parameter int unsigned PC_W  = PC_W_DEF,
   parameter int unsigned DEPTH = RAS_DEPTH_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  ras_op_t         op,
   input  logic [PC_W-1:0] push_data,
   output logic [PC_W-1:0] top,
   output logic            empty,
   output logic            full,
   output logic            ovf,
   output logic            unf
);

   localparam int unsigned      PTR_W   = ptr_width(DEPTH);
   localparam int unsigned      CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

   logic [PC_W-1:0]  r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_ovf;
   logic             r_unf;
   logic [PTR_W-1:0] w_top_ptr;

   // r_wr_ptr is the next free slot; once full it also addresses the oldest entry
   assign w_top_ptr = r_wr_ptr - PTR_W'(1);
   assign top       = r_mem[w_top_ptr];
   assign empty     = (r_count == '0);
   assign full      = (r_count == CNT_MAX);
   assign ovf       = r_ovf;
   assign unf       = r_unf;

   always_ff @(posedge clk) begin
      if (!rst && op == RAS_PUSH) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
      end else begin
         case (op)
            RAS_PUSH: begin
               r_wr_ptr <= r_wr_ptr + PTR_W'(1);
               if (full) begin
                  r_ovf <= 1'b1;
               end else begin
                  r_count <= r_count + CNT_W'(1);
               end
            end
            RAS_POP: begin
               if (empty) begin
                  r_unf <= 1'b1;
               end else begin
                  r_wr_ptr <= w_top_ptr;
                  r_count  <= r_count - CNT_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// pc_sequencer : RUN/HALT program-counter sequencer with redirect, call/return
// Revision     : 1.0
// ============================================================================
`default_nettype none

module pc_sequencer
   import kgp_pc_pkg::*;
#(
   parameter int unsigned     PC_W      = PC_W_DEF,
   parameter logic [PC_W-1:0] RESET_VEC = PC_W'(RESET_VEC_DEF),
   parameter int unsigned     INC       = INC_DEF,
   parameter int unsigned     RAS_DEPTH = RAS_DEPTH_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [PC_W-1:0] redirect_target,
   input  logic            call,
   input  logic            ret,
   input  logic            halt_req,
   input  logic            resume,
   output logic [PC_W-1:0] pc,
   output logic            halted,
   output logic            ras_empty,
   output logic            ras_full,
   output logic            ras_ovf,
   output logic            ras_unf
);

   pc_state_t       r_state;
   pc_state_t       w_state_next;
   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] w_pc_next;
   logic [PC_W-1:0] w_pc_inc;
   logic [PC_W-1:0] w_ras_top;
   ras_op_t         w_ras_op;

   assign w_pc_inc = r_pc + PC_W'(INC);

   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_ras_op     = RAS_NOP;
      if (!stall) begin
         case (r_state)
            ST_RUN: begin
               if (halt_req) begin
                  w_state_next = ST_HALT;
               end else if (redirect_valid) begin
                  w_pc_next = redirect_target;
                  if (call) begin
                     w_ras_op = RAS_PUSH;
                  end
               end else if (ret) begin
                  // an empty-stack pop still reaches the stack so it can flag underflow
                  w_ras_op  = RAS_POP;
                  w_pc_next = ras_empty ? w_pc_inc : w_ras_top;
               end else begin
                  w_pc_next = w_pc_inc;
               end
            end
            ST_HALT: begin
               if (resume && !halt_req) begin
                  w_state_next = ST_RUN;
               end
            end
            default: begin
               w_state_next = ST_RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_RUN;
         r_pc    <= RESET_VEC;
      end else begin
         r_state <= w_state_next;
         r_pc    <= w_pc_next;
      end
   end

   pc_ras #(
      .PC_W  (PC_W),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst       (rst),
      .op        (w_ras_op),
      .push_data (w_pc_inc),
      .top       (w_ras_top),
      .empty     (ras_empty),
      .full      (ras_full),
      .ovf       (ras_ovf),
      .unf       (ras_unf)
   );

   assign pc     = r_pc;
   assign halted = (r_state == ST_HALT);

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// tb_pc_sequencer : scoreboard bench for pc_sequencer
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

   localparam int unsigned PC_W    = 32;
   localparam logic [31:0] RST_VEC = 32'h0;
   localparam logic [31:0] INC_V   = 32'd4;
   localparam int unsigned DEPTH   = 4;

   logic        clk = 1'b0;
   logic        rst, stall, redirect_valid, call, ret, halt_req, resume;
   logic [31:0] redirect_target;
   logic [31:0] pc;
   logic        halted, ras_empty, ras_full, ras_ovf, ras_unf;

   always #5 clk = ~clk;

   pc_sequencer #(
      .PC_W      (PC_W),
      .RESET_VEC (RST_VEC),
      .INC       (4),
      .RAS_DEPTH (DEPTH)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .call            (call),
      .ret             (ret),
      .halt_req        (halt_req),
      .resume          (resume),
      .pc              (pc),
      .halted          (halted),
      .ras_empty       (ras_empty),
      .ras_full        (ras_full),
      .ras_ovf         (ras_ovf),
      .ras_unf         (ras_unf)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic        halted;
      logic        empty;
      logic        full;
      logic        ovf;
      logic        unf;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] m_stk[$];
   logic [31:0] m_pc = '0;
   logic        m_halt = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference behaviour: stack kept as a queue, newest at the back
   task automatic model_step();
      logic [31:0] tmp;
      if (rst) begin
         m_pc   = RST_VEC;
         m_halt = 1'b0;
         m_ovf  = 1'b0;
         m_unf  = 1'b0;
         m_stk.delete();
      end else if (!stall) begin
         if (!m_halt) begin
            if (halt_req) begin
               m_halt = 1'b1;
            end else if (redirect_valid) begin
               if (call) begin
                  if (m_stk.size() == DEPTH) begin
                     tmp   = m_stk.pop_front();
                     m_ovf = 1'b1;
                  end
                  m_stk.push_back(m_pc + INC_V);
               end
               m_pc = redirect_target;
            end else if (ret) begin
               if (m_stk.size() != 0) begin
                  m_pc = m_stk.pop_back();
               end else begin
                  m_pc  = m_pc + INC_V;
                  m_unf = 1'b1;
               end
            end else begin
               m_pc = m_pc + INC_V;
            end
         end else if (resume && !halt_req) begin
            m_halt = 1'b0;
         end
      end
   endtask

   task automatic clear_inputs();
      rst            = 1'b0;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      call           = 1'b0;
      ret            = 1'b0;
      halt_req       = 1'b0;
      resume         = 1'b0;
   endtask

   task automatic tick();
      exp_t e;
      model_step();
      e.pc     = m_pc;
      e.halted = m_halt;
      e.empty  = (m_stk.size() == 0);
      e.full   = (m_stk.size() == DEPTH);
      e.ovf    = m_ovf;
      e.unf    = m_unf;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check_eq("pc",        pc,              e.pc);
      check_eq("halted",    32'(halted),    32'(e.halted));
      check_eq("ras_empty", 32'(ras_empty), 32'(e.empty));
      check_eq("ras_full",  32'(ras_full),  32'(e.full));
      check_eq("ras_ovf",   32'(ras_ovf),   32'(e.ovf));
      check_eq("ras_unf",   32'(ras_unf),   32'(e.unf));
      clear_inputs();
   endtask

   task automatic do_redirect(input logic [31:0] tgt, input logic is_call);
      redirect_valid  = 1'b1;
      redirect_target = tgt;
      call            = is_call;
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] ret_addr [4];
      ret_addr[0] = 32'h504; ret_addr[1] = 32'h404;
      ret_addr[2] = 32'h304; ret_addr[3] = 32'h204;
      redirect_target = '0;
      clear_inputs();
      @(negedge clk);

      // Reset and free run
      rst = 1'b1;
      tick();
      check_eq("rst_pc",    pc,              32'h0);
      check_eq("rst_empty", 32'(ras_empty), 32'd1);
      for (int i = 1; i <= 4; i++) begin
         tick();
         check_eq("freerun_pc", pc, 32'(i * 4));
      end

      // Call then return
      do_redirect(32'h100, 1'b1);
      check_eq("call_pc", pc, 32'h100);
      tick();
      check_eq("callee_pc", pc, 32'h104);
      ret = 1'b1;
      tick();
      check_eq("ret_pc",    pc,              32'h14);
      check_eq("ret_empty", 32'(ras_empty), 32'd1);

      // Five nested calls overflow a 4-deep stack
      for (int k = 0; k < 5; k++) begin
         do_redirect(32'h200 + 32'(k) * 32'h100, 1'b1);
      end
      check_eq("nest_pc",   pc,             32'h600);
      check_eq("nest_full", 32'(ras_full), 32'd1);
      check_eq("nest_ovf",  32'(ras_ovf),  32'd1);
      for (int k = 0; k < 4; k++) begin
         ret = 1'b1;
         tick();
         check_eq("nest_ret_pc", pc, ret_addr[k]);
      end
      ret = 1'b1;
      tick();
      check_eq("unf_pc",  pc,            32'h208);
      check_eq("unf_flg", 32'(ras_unf), 32'd1);

      // Call without redirect is ignored
      call = 1'b1;
      tick();
      check_eq("lone_call_pc", pc, 32'h20C);

      // Stall freezes a pending redirect
      for (int k = 0; k < 3; k++) begin
         stall = 1'b1;
         do_redirect(32'h800, 1'b0);
         check_eq("stall_pc", pc, 32'h20C);
      end
      do_redirect(32'h800, 1'b0);
      check_eq("unstall_pc", pc, 32'h800);

      // Halt, ignored redirect, resume
      do_redirect(32'h20, 1'b0);
      halt_req = 1'b1;
      tick();
      check_eq("halt_flag", 32'(halted), 32'd1);
      ret = 1'b1;
      do_redirect(32'h900, 1'b1);
      check_eq("halt_hold_pc", pc, 32'h20);
      halt_req = 1'b1;
      resume   = 1'b1;
      tick();
      check_eq("halt_resume_both", 32'(halted), 32'd1);
      stall  = 1'b1;
      resume = 1'b1;
      tick();
      check_eq("halt_stall_resume", 32'(halted), 32'd1);
      resume = 1'b1;
      tick();
      check_eq("resume_halted", 32'(halted), 32'd0);
      check_eq("resume_pc",     pc,           32'h20);
      tick();
      check_eq("post_resume_pc", pc, 32'h24);

      // Wrap of pushed address and of free-run PC
      do_redirect(32'hFFFF_FFFC, 1'b0);
      do_redirect(32'h40, 1'b1);
      ret = 1'b1;
      tick();
      check_eq("wrap_push_ret", pc, 32'h0);
      do_redirect(32'hFFFF_FFFC, 1'b0);
      tick();
      check_eq("wrap_free_pc", pc, 32'h0);

      // Reset coinciding with a call
      rst = 1'b1;
      do_redirect(32'h900, 1'b1);
      check_eq("rst_call_pc",    pc,              RST_VEC);
      check_eq("rst_call_empty", 32'(ras_empty), 32'd1);
      check_eq("rst_call_ovf",   32'(ras_ovf),   32'd0);
      check_eq("rst_call_unf",   32'(ras_unf),   32'd0);

      // Reset overrides stall while halted
      halt_req = 1'b1;
      tick();
      rst   = 1'b1;
      stall = 1'b1;
      tick();
      check_eq("rst_stall_halted", 32'(halted), 32'd0);

      // Randomised traffic against the model
      for (int n = 0; n < 400; n++) begin
         rst             = ($urandom_range(0, 63) == 0);
         stall           = ($urandom_range(0, 7) == 0);
         halt_req        = ($urandom_range(0, 15) == 0);
         redirect_valid  = ($urandom_range(0, 3) == 0);
         call            = ($urandom_range(0, 1) == 1);
         ret             = ($urandom_range(0, 3) == 0);
         resume          = ($urandom_range(0, 2) == 0);
         redirect_target = $urandom() & 32'hFFFF_FFFC;
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
